// File: rtl/decoder_sel_sequencer.sv
// Select-code sequencer feeding a 3-to-8 one-hot decoder: up, down, bounce and
// one-shot sequences stepped by a programmable prescaler, with step/wrap strobes.
module decoder_sel_sequencer #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] div,
  input  logic                  start,
  input  logic                  load,
  input  logic [2:0]            load_val,
  output logic [2:0]            sel,
  output logic                  tick,
  output logic                  wrap,
  output logic                  busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  state_t                r_state;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  r_dir;
  logic [2:0]            r_sel;
  logic                  r_tick;
  logic                  r_wrap;
  logic                  r_busy;

  state_t                w_state_next;
  logic [PRESCALE_W-1:0] w_pcnt_next;
  logic                  w_dir_next;
  logic [2:0]            w_sel_next;
  logic                  w_tick_next;
  logic                  w_wrap_next;
  logic                  w_active;
  logic                  w_step;

  // One-shot mode only counts while a run is in progress.
  assign w_active = (mode != MODE_ONESHOT) || (r_state == S_RUN);
  assign w_step   = en && w_active && (r_pcnt >= div);

  always_comb begin
    w_state_next = r_state;
    w_pcnt_next  = r_pcnt;
    w_dir_next   = r_dir;
    w_sel_next   = r_sel;
    w_tick_next  = 1'b0;
    w_wrap_next  = 1'b0;

    if (load) begin
      w_sel_next   = load_val;
      w_pcnt_next  = '0;
      w_dir_next   = DIR_UP;
      w_state_next = S_IDLE;
    end else if ((mode == MODE_ONESHOT) && (r_state == S_IDLE)) begin
      if (en && start) begin
        w_sel_next   = 3'd0;
        w_pcnt_next  = '0;
        w_state_next = S_RUN;
      end
    end else begin
      // Abandoning a one-shot run by switching mode drops busy immediately.
      if ((mode != MODE_ONESHOT) && (r_state == S_RUN)) begin
        w_state_next = S_IDLE;
      end
      if (en && w_active) begin
        if (w_step) begin
          w_pcnt_next = '0;
          w_tick_next = 1'b1;
          case (mode)
            MODE_UP: begin
              w_sel_next  = r_sel + 3'd1;
              w_wrap_next = (r_sel == 3'd7);
            end
            MODE_DOWN: begin
              w_sel_next  = r_sel - 3'd1;
              w_wrap_next = (r_sel == 3'd0);
            end
            MODE_BOUNCE: begin
              if ((r_dir == DIR_UP) && (r_sel == 3'd7)) begin
                w_dir_next = DIR_DOWN;
                w_sel_next = 3'd6;
              end else if ((r_dir == DIR_DOWN) && (r_sel == 3'd0)) begin
                w_dir_next = DIR_UP;
                w_sel_next = 3'd1;
              end else if (r_dir == DIR_UP) begin
                w_sel_next = r_sel + 3'd1;
              end else begin
                w_sel_next = r_sel - 3'd1;
              end
              w_wrap_next = (w_sel_next == 3'd7) || (w_sel_next == 3'd0);
            end
            default: begin
              w_sel_next = r_sel + 3'd1;
              if (r_sel == 3'd7) begin
                w_wrap_next  = 1'b1;
                w_state_next = S_IDLE;
              end
            end
          endcase
        end else begin
          w_pcnt_next = r_pcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pcnt  <= '0;
      r_dir   <= DIR_UP;
      r_sel   <= 3'd0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pcnt  <= w_pcnt_next;
      r_dir   <= w_dir_next;
      r_sel   <= w_sel_next;
      r_tick  <= w_tick_next;
      r_wrap  <= w_wrap_next;
      r_busy  <= (w_state_next == S_RUN);
    end
  end

  assign sel  = r_sel;
  assign tick = r_tick;
  assign wrap = r_wrap;
  assign busy = r_busy;

endmodule

// File: doc/decoder_sel_sequencer.md
Name: decoder_sel_sequencer

Overview:
- Upstream stage of the 3-to-8 one-hot decoder. Generates the 3-bit select code that the decoder converts into a one-hot 8-bit output.
- Steps the select through programmable sequences: up, down, bounce and one-shot, at a rate set by a prescaler.
- Emits step and wrap strobes for downstream timing. Typical uses are LED scanning, digit multiplexing and channel polling.

Parameters:
- PRESCALE_W, 16, width of the prescaler divider input and of the internal prescale counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  advance enable. When low, the prescaler and the sequence hold.
- mode  input  2  00 = up, 01 = down, 10 = bounce, 11 = one-shot up.
- div  input  PRESCALE_W  step period minus 1. One step occurs every div+1 enabled cycles.
- start  input  1  one-shot trigger, sampled only in mode 11.
- load  input  1  synchronous preset of the select code.
- load_val  input  3  preset value.
- sel  output  3  select code to the decoder.
- tick  output  1  1-cycle pulse, coincident with every new sel value produced by a step.
- wrap  output  1  1-cycle pulse, coincident with the step that crosses or reaches a sequence end.
- busy  output  1  high while a one-shot run is in progress.

Behaviour:
- One clock, synchronous active-high reset; rst is sampled on the rising clk edge.
- All outputs are registered.
- Reset values:
  - sel = 0, tick = 0, wrap = 0, busy = 0.
  - Prescale counter pcnt = 0, direction dir = up, FSM = IDLE.
- Priority, highest first: rst, load, start, step.
- tick and wrap default to 0 every cycle unless a step sets them.
- Prescaler:
  - While en is high and the block is active, pcnt increments each cycle.
  - When pcnt >= div, a step occurs and pcnt returns to 0.
  - div = 0 gives a step every enabled cycle.
  - The >= compare makes a mid-count reduction of div produce a step on the next enabled cycle.
  - "Active" means modes 00, 01 and 10 always, and mode 11 only while busy = 1.
- en low: pcnt, sel, dir and the FSM all hold; tick = wrap = 0.
- load:
  - sel <= load_val, pcnt <= 0, dir <= up, busy <= 0, FSM <= IDLE.
  - No tick or wrap is generated.
  - load takes effect regardless of en.
- Mode 00 (up): sel <= sel + 1 modulo 8. wrap = 1 on the 7 -> 0 step.
- Mode 01 (down): sel <= sel - 1 modulo 8. wrap = 1 on the 0 -> 7 step.
- Mode 10 (bounce):
  - Sequence is 0, 1, …, 7, 6, …, 1, 0, 1, …
  - On a step with dir = up and sel = 7: dir <= down, sel <= 6.
  - On a step with dir = down and sel = 0: dir <= up, sel <= 1.
  - Otherwise sel moves one position in the direction of dir.
  - wrap = 1 on any step whose new sel is 7 or 0.
  - dir is retained when switching into bounce. Modes 00 and 01 do not modify dir.
- Mode 11 (one-shot), FSM states IDLE and RUN:
  - IDLE: sel holds. start = 1 -> sel <= 0, pcnt <= 0, busy <= 1, FSM <= RUN. The start cycle produces no tick.
  - RUN: each step increments sel and produces tick.
  - On the step from 7: sel <= 0, tick = 1, wrap = 1, busy <= 0, FSM <= IDLE.
  - start while in RUN is ignored; there is no retrigger.
  - A run therefore produces exactly 8 ticks: values 1..7 then 0.
- Mode change:
  - The new mode is sampled on every cycle; a change takes effect on the next step.
  - Leaving mode 11 while in RUN: busy <= 0 and FSM <= IDLE in the next cycle. sel holds.
- Reset mid-operation restores all reset values in the next cycle, regardless of the other inputs.
- Latency: sel, tick and wrap update in the cycle after the enabled cycle on which pcnt >= div.

Test Plan:
- rst held 2 cycles, then released with mode = 00, div = 0, en = 1 -> sel steps 1, 2, …, 7, 0, 1 on consecutive cycles. tick is high every cycle. wrap is high only in the cycle sel = 0.
- mode = 01, div = 3, sel starting at 0 -> sel = 7 after 4 cycles with tick = wrap = 1, then 6 after another 4 cycles. tick is high 1 cycle in every 4.
- mode = 10, div = 0 -> sel sequence 1..7, 6..0, 1. wrap is high exactly in the cycles sel = 7 and sel = 0. The bounce-up at 0 goes to 1 without repeating 0.
- mode = 11, div = 1, start pulse -> busy rises next cycle. 8 ticks follow, 2 cycles apart. The last tick has sel = 0 and wrap = 1, and busy falls with it. A second start during RUN changes nothing.
- load_val = 5 with load = 1 while en = 0 -> sel = 5 next cycle, no tick. With en = 1 and mode = 00, the next step gives sel = 6.
- en low for 10 cycles mid-count with div = 4 -> sel and pcnt freeze. After en rises, the step arrives exactly after the remaining count. rst asserted in RUN -> sel = 0 and busy = 0 next cycle.
